// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one single-port memory between the instruction-fetch (I) and the
// load/store (D) requesters. It is a fixed-latency sequencer:
//   IDLE   : wait for a request, pick a winner and latch its command
//   ACCESS : drive the memory port for MEM_LAT cycles from the latched command
//   DONE   : one-cycle ack to the winner, read data held in its rdata register
// D normally has priority. A streak counter lets D win at most MAX_STREAK
// times in a row while I is waiting; after that I is forced through.
//
// Ports
//   clk, rst_n          clock (posedge) and asynchronous active-low reset
//   i_req/i_adr         fetch request (level, held until i_ack) and byte address
//   i_rdata/i_ack       fetched word and its one-cycle completion pulse
//   d_req/d_we/d_adr/   data request (level, held until d_ack), 1=store,
//   d_wdata             byte address and store data
//   d_rdata/d_ack       load word and its one-cycle completion pulse
//   m_en/m_we/m_adr/    memory port: active, write enable, byte address,
//   m_wdata/m_rdata     write data, read data (valid by the last ACCESS cycle)
//   owner               0=I, 1=D; meaningful while m_en=1
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
   parameter int MEM_LAT    = 2,
   parameter int MAX_STREAK = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        i_req,
   input  logic [31:0] i_adr,
   output logic [31:0] i_rdata,
   output logic        i_ack,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_adr,
   input  logic [31:0] d_wdata,
   output logic [31:0] d_rdata,
   output logic        d_ack,
   output logic        m_en,
   output logic        m_we,
   output logic [31:0] m_adr,
   output logic [31:0] m_wdata,
   input  logic [31:0] m_rdata,
   output logic        owner
);

   // A one-bit counter is kept even for MEM_LAT=1 so the vector is never empty.
   localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
   localparam int STK_W = $clog2(MAX_STREAK + 1);

   localparam logic [CNT_W-1:0] CNT_INIT   = CNT_W'(MEM_LAT - 1);
   localparam logic [STK_W-1:0] STREAK_MAX = STK_W'(MAX_STREAK);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   state_t            state_reg,   state_next;
   logic [CNT_W-1:0]  cnt_reg,     cnt_next;
   logic [STK_W-1:0]  streak_reg,  streak_next;
   logic              owner_reg,   owner_next;
   logic              we_reg,      we_next;
   logic [31:0]       adr_reg,     adr_next;
   logic [31:0]       wdata_reg,   wdata_next;
   logic [31:0]       i_rdata_reg, i_rdata_next;
   logic [31:0]       d_rdata_reg, d_rdata_next;
   logic              grant_d;

   // ---------------------------------------------------------------- state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         streak_reg  <= '0;
         owner_reg   <= 1'b0;
         we_reg      <= 1'b0;
         adr_reg     <= '0;
         wdata_reg   <= '0;
         i_rdata_reg <= '0;
         d_rdata_reg <= '0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         streak_reg  <= streak_next;
         owner_reg   <= owner_next;
         we_reg      <= we_next;
         adr_reg     <= adr_next;
         wdata_reg   <= wdata_next;
         i_rdata_reg <= i_rdata_next;
         d_rdata_reg <= d_rdata_next;
      end
   end

   // ------------------------------------------------- next state / datapath
   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      streak_next  = streak_reg;
      owner_next   = owner_reg;
      we_next      = we_reg;
      adr_next     = adr_reg;
      wdata_next   = wdata_reg;
      i_rdata_next = i_rdata_reg;
      d_rdata_next = d_rdata_reg;

      // D wins unless I is waiting and D has already used up its streak.
      grant_d = d_req && !(i_req && (streak_reg == STREAK_MAX));

      case (state_reg)
         IDLE: begin
            if (i_req || d_req) begin
               state_next = ACCESS;
               cnt_next   = CNT_INIT;
               owner_next = grant_d;
               if (grant_d) begin
                  adr_next   = d_adr;
                  we_next    = d_we;
                  wdata_next = d_wdata;
                  // Only grants that made I wait extend the streak; saturate
                  // as a guard even though the limit already blocks D there.
                  if (!i_req)
                     streak_next = '0;
                  else if (streak_reg != STREAK_MAX)
                     streak_next = streak_reg + 1'b1;
               end else begin
                  adr_next    = i_adr;
                  we_next     = 1'b0;
                  wdata_next  = '0;
                  streak_next = '0;
               end
            end
         end

         ACCESS: begin
            if (cnt_reg != '0) begin
               cnt_next = cnt_reg - 1'b1;
            end else begin
               state_next = DONE;
               // Stores leave the read-data register untouched.
               if (!we_reg) begin
                  if (owner_reg)
                     d_rdata_next = m_rdata;
                  else
                     i_rdata_next = m_rdata;
               end
            end
         end

         DONE: begin
            // Requests are ignored here; the requester drops its request on
            // the edge that ends this cycle.
            state_next = IDLE;
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   // ---------------------------------------------------------------- outputs
   // Port signals are gated by ACCESS so the memory sees nothing in IDLE/DONE.
   assign m_en    = (state_reg == ACCESS);
   assign m_we    = m_en & we_reg;
   assign m_adr   = m_en ? adr_reg   : '0;
   assign m_wdata = m_en ? wdata_reg : '0;
   assign owner   = m_en & owner_reg;

   assign i_ack   = (state_reg == DONE) & ~owner_reg;
   assign d_ack   = (state_reg == DONE) &  owner_reg;

   assign i_rdata = i_rdata_reg;
   assign d_rdata = d_rdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_port_arbiter
//
// Directed stimulus against two arbiters: u_dut (MEM_LAT=2, MAX_STREAK=4) and
// u_dut1 (MEM_LAT=1) for back-to-back single-cycle accesses. Both share a
// behavioural memory image. Stimulus pushes the expected ack (owner and read
// data) into a queue; a negedge monitor pops and compares on every ack and
// also checks port behaviour while m_en is high.
// -----------------------------------------------------------------------------
module tb_mem_port_arbiter;

   logic        clk;
   logic        rst_n;

   // main DUT, MEM_LAT=2
   logic        i_req, d_req, d_we;
   logic [31:0] i_adr, d_adr, d_wdata;
   logic [31:0] i_rdata, d_rdata;
   logic        i_ack, d_ack;
   logic        m_en, m_we, owner;
   logic [31:0] m_adr, m_wdata, m_rdata;

   // second DUT, MEM_LAT=1
   logic        b_i_req, b_d_req, b_d_we;
   logic [31:0] b_i_adr, b_d_adr, b_d_wdata;
   logic [31:0] b_i_rdata, b_d_rdata;
   logic        b_i_ack, b_d_ack;
   logic        b_m_en, b_m_we, b_owner;
   logic [31:0] b_m_adr, b_m_wdata, b_m_rdata;

   logic [31:0] mem [0:4095];

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int ack_seen   = 0;
   int we_cycles  = 0;

   typedef struct packed {
      logic        is_d;
      logic [31:0] data;
   } exp_t;
   exp_t exp_q[$];

   mem_port_arbiter #(.MEM_LAT(2), .MAX_STREAK(4)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .i_req(i_req), .i_adr(i_adr), .i_rdata(i_rdata), .i_ack(i_ack),
      .d_req(d_req), .d_we(d_we), .d_adr(d_adr), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack),
      .m_en(m_en), .m_we(m_we), .m_adr(m_adr), .m_wdata(m_wdata),
      .m_rdata(m_rdata), .owner(owner)
   );

   mem_port_arbiter #(.MEM_LAT(1), .MAX_STREAK(4)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
      .i_req(b_i_req), .i_adr(b_i_adr), .i_rdata(b_i_rdata), .i_ack(b_i_ack),
      .d_req(b_d_req), .d_we(b_d_we), .d_adr(b_d_adr), .d_wdata(b_d_wdata),
      .d_rdata(b_d_rdata), .d_ack(b_d_ack),
      .m_en(b_m_en), .m_we(b_m_we), .m_adr(b_m_adr), .m_wdata(b_m_wdata),
      .m_rdata(b_m_rdata), .owner(b_owner)
   );

   assign m_rdata   = mem[m_adr[13:2]];
   assign b_m_rdata = mem[b_m_adr[13:2]];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   always @(posedge clk) cyc <= cyc + 1;

   // memory image: preload, then apply writes from the main DUT port
   initial begin
      for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
      mem[16]   = 32'hDEADBEEF;   // 0x40
      mem[17]   = 32'h0BADF00D;   // 0x44
      mem[18]   = 32'h12345678;   // 0x48
      mem[128]  = 32'h5555AAAA;   // 0x200
      mem[2049] = 32'hFFFF0000;   // 0x2004
      for (int n = 0; n < 5; n++) mem[64 + n] = 32'hA0000000 + n; // 0x100..
      forever begin
         @(posedge clk);
         if (m_en && m_we) mem[m_adr[13:2]] = m_wdata;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got=%h want=%h", name, act, exp);
      end
   endtask

   // sel: 0=wait for i_ack, 1=wait for d_ack, 2=either. Returns at posedge+1.
   task automatic wait_ack(input int sel, output int at, output logic was_d);
      at    = -1;
      was_d = 1'b0;
      for (int n = 0; n < 40; n++) begin
         @(posedge clk); #1;
         if ((sel != 1 && i_ack) || (sel != 0 && d_ack)) begin
            at    = cyc;
            was_d = d_ack;
            break;
         end
      end
      if (at < 0) chk("ack_timeout", 32'd0, 32'd1);
   endtask

   // ------------------------------------------------------------- monitor
   initial begin
      logic        prev_en  = 1'b0;
      logic [31:0] prev_adr = '0;
      int          run_len  = 0;
      logic        b_prev_en = 1'b0;
      exp_t        e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_en   = 1'b0;
            run_len   = 0;
            b_prev_en = 1'b0;
         end else begin
            if (i_ack && d_ack) chk("both_acks", 32'd1, 32'd0);
            if (m_en) begin
               if (exp_q.size() > 0) chk("owner", {31'd0, owner}, {31'd0, exp_q[0].is_d});
               if (m_we) we_cycles++;
               if (prev_en) chk("m_adr_stable", m_adr, prev_adr);
               run_len++;
            end else if (prev_en) begin
               chk("m_en_len", run_len, 32'd2);
               run_len = 0;
            end
            prev_en  = m_en;
            prev_adr = m_adr;

            if (i_ack || d_ack) begin
               ack_seen++;
               if (exp_q.size() == 0) begin
                  chk("unexpected_ack", 32'd1, 32'd0);
               end else begin
                  e = exp_q.pop_front();
                  $display("TXN %s ack rdata=%h expected %s %h",
                           d_ack ? "D" : "I", d_ack ? d_rdata : i_rdata,
                           e.is_d ? "D" : "I", e.data);
                  chk("ack_owner", {31'd0, d_ack}, {31'd0, e.is_d});
                  chk("ack_rdata", d_ack ? d_rdata : i_rdata, e.data);
               end
            end

            // MEM_LAT=1 instance: each access occupies exactly one cycle
            if (b_m_en && b_prev_en) chk("b_m_en_len", 32'd2, 32'd1);
            if (b_i_ack && b_d_ack)  chk("b_both_acks", 32'd1, 32'd0);
            b_prev_en = b_m_en;
         end
      end
   end

   // ------------------------------------------------------------ stimulus
   initial begin
      int          c0, at, ad, ai, bprev;
      logic        wd;
      logic [31:0] last_d;
      int          we0, a0;

      rst_n = 1'b0;
      i_req = 0; i_adr = '0; d_req = 0; d_we = 0; d_adr = '0; d_wdata = '0;
      b_i_req = 0; b_i_adr = '0; b_d_req = 0; b_d_we = 0; b_d_adr = '0; b_d_wdata = '0;
      last_d = '0;

      repeat (3) @(posedge clk); #1;
      chk("rst_ctl", {27'd0, i_ack, d_ack, m_en, m_we, owner}, 32'd0);
      chk("rst_m_adr", m_adr, 32'd0);
      chk("rst_m_wdata", m_wdata, 32'd0);
      chk("rst_i_rdata", i_rdata, 32'd0);
      chk("rst_d_rdata", d_rdata, 32'd0);
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;

      // fetch from 0x40
      exp_q.push_back('{is_d: 1'b0, data: 32'hDEADBEEF});
      we0 = we_cycles;
      i_adr = 32'h40; i_req = 1'b1; c0 = cyc;
      wait_ack(0, at, wd);
      chk("fetch_latency", at - c0, 32'd3);
      @(posedge clk); #1 i_req = 1'b0;
      chk("fetch_no_write", we_cycles - we0, 32'd0);

      // store 0x1234 to 0x2004
      exp_q.push_back('{is_d: 1'b1, data: last_d});
      we0 = we_cycles;
      d_we = 1'b1; d_adr = 32'h2004; d_wdata = 32'h1234; d_req = 1'b1; c0 = cyc;
      wait_ack(1, at, wd);
      chk("store_latency", at - c0, 32'd3);
      @(posedge clk); #1 d_req = 1'b0; d_we = 1'b0;
      chk("store_we_cycles", we_cycles - we0, 32'd2);
      chk("store_mem", mem[2049], 32'h1234);
      chk("i_rdata_hold", i_rdata, 32'hDEADBEEF);

      // simultaneous requests: D first, I acked 4 cycles after d_ack
      exp_q.push_back('{is_d: 1'b1, data: 32'h5555AAAA});
      exp_q.push_back('{is_d: 1'b0, data: 32'h0BADF00D});
      i_adr = 32'h44; d_adr = 32'h200; i_req = 1'b1; d_req = 1'b1;
      wait_ack(1, ad, wd);
      @(posedge clk); #1 d_req = 1'b0;
      wait_ack(0, ai, wd);
      chk("i_after_d", ai - ad, 32'd4);
      @(posedge clk); #1 i_req = 1'b0;
      last_d = 32'h5555AAAA;

      // streak limit: D held with I waiting -> 4 D, then I, then D again
      for (int n = 0; n < 4; n++)
         exp_q.push_back('{is_d: 1'b1, data: 32'hA0000000 + n});
      exp_q.push_back('{is_d: 1'b0, data: 32'h12345678});
      exp_q.push_back('{is_d: 1'b1, data: 32'hA0000004});
      i_adr = 32'h48; d_adr = 32'h100; d_we = 1'b0;
      i_req = 1'b1; d_req = 1'b1;
      for (int k = 0; k < 6; k++) begin
         wait_ack(2, at, wd);
         chk("streak_order", {31'd0, wd}, (k == 4) ? 32'd0 : 32'd1);
         @(posedge clk); #1;
         if (!wd) i_req = 1'b0;
         else     d_adr = d_adr + 32'd4;
         if (k == 5) d_req = 1'b0;
      end

      // reset during ACCESS: outputs drop at once, no ack, fresh request works
      i_adr = 32'h40; i_req = 1'b1;
      begin
         int guard = 0;
         while (!m_en && guard < 10) begin
            @(posedge clk); #1;
            guard++;
         end
      end
      chk("reached_access", {31'd0, m_en}, 32'd1);
      rst_n = 1'b0; #1;
      chk("midrst_ctl", {27'd0, i_ack, d_ack, m_en, m_we, owner}, 32'd0);
      chk("midrst_m_adr", m_adr, 32'd0);
      chk("midrst_i_rdata", i_rdata, 32'd0);
      i_req = 1'b0;
      a0 = ack_seen;
      @(posedge clk); #1 rst_n = 1'b1;
      repeat (6) @(posedge clk); #1;
      chk("no_ack_after_rst", ack_seen - a0, 32'd0);
      exp_q.push_back('{is_d: 1'b0, data: 32'hDEADBEEF});
      i_req = 1'b1; c0 = cyc;
      wait_ack(0, at, wd);
      chk("post_rst_latency", at - c0, 32'd3);
      @(posedge clk); #1 i_req = 1'b0;

      // MEM_LAT=1 back-to-back D loads: one ack every 3 cycles
      b_d_adr = 32'h100; b_d_req = 1'b1; bprev = -1;
      for (int k = 0; k < 3; k++) begin
         at = -1;
         for (int n = 0; n < 20; n++) begin
            @(posedge clk); #1;
            if (b_d_ack) begin at = cyc; break; end
         end
         if (at < 0) chk("b_ack_timeout", 32'd0, 32'd1);
         $display("TXN B D ack rdata=%h expected %h", b_d_rdata, 32'hA0000000 + k);
         chk("b_rdata", b_d_rdata, 32'hA0000000 + k);
         if (bprev >= 0) chk("b_ack_interval", at - bprev, 32'd3);
         bprev = at;
         @(posedge clk); #1 b_d_adr = b_d_adr + 32'd4;
         bprev = bprev; // interval measured ack-to-ack
      end
      b_d_req = 1'b0;

      repeat (4) @(posedge clk); #1;
      chk("queue_drained", exp_q.size(), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

endmodule
